// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake of the UART transmitter: producer drives data/valid,
// the transmitter answers with ready (FIFO not full).
interface uart_tx_fifo_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (output tx_data, output tx_valid, input  tx_ready);
   modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; frames are sent back-to-back while
// enable is high, with an internal baud divider that restarts every frame.
module uart_tx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int BAUD       = 9600,
   parameter int SYS_CLK    = 12000000,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable_i,
   uart_tx_fifo_if.slave                 wr_if,
   output logic                          tx_wire_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
   localparam int DIV = SYS_CLK / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int NW  = AW + 1;
   localparam int BW  = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
   localparam logic [CW-1:0] LAST_TICK = CW'(DIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wptr_q, rptr_q;
   logic [NW-1:0]        cnt_q, cnt_d;
   state_t               state_q, state_d;
   logic [CW-1:0]        baud_q, baud_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_q, par_d;
   logic                 wire_q, wire_d;
   logic                 push, pop, tick, can_pop, head_par;
   logic [DATA_BITS-1:0] head;

   assign wr_if.tx_ready = (cnt_q != NW'(FIFO_DEPTH));
   assign push           = wr_if.tx_valid && wr_if.tx_ready;
   assign can_pop        = enable_i && (cnt_q != '0);
   assign tick           = (baud_q == LAST_TICK);
   assign head           = mem_q[rptr_q];
   // Parity is captured at pop time because the shift register is consumed.
   assign head_par       = (PARITY == 1) ? ~^head : ^head;
   assign cnt_d          = cnt_q + NW'(push) - NW'(pop);

   assign tx_wire_o    = wire_q;
   assign busy_o       = (state_q != S_IDLE);
   assign fifo_count_o = cnt_q;

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= wr_if.tx_data;
   end

   always_comb begin
      state_d = state_q;
      baud_d  = tick ? '0 : baud_q + 1'b1;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            pop    = can_pop;
         end
         S_START: if (tick) state_d = S_DATA;
         S_DATA: if (tick) begin
            shreg_d = shreg_q >> 1;
            if (bit_q == LAST_DATA) begin
               bit_d   = '0;
               state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
               bit_d = bit_q + 1'b1;
            end
         end
         S_PAR: if (tick) state_d = S_STOP;
         S_STOP: if (tick) begin
            if (bit_q == LAST_STOP) begin
               bit_d   = '0;
               state_d = S_IDLE;
               pop     = can_pop;
            end else begin
               bit_d = bit_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A pop always launches a fresh frame, from IDLE or straight out of STOP.
      if (pop) begin
         state_d = S_START;
         shreg_d = head;
         par_d   = head_par;
         baud_d  = '0;
         bit_d   = '0;
      end
      case (state_d)
         S_START: wire_d = 1'b0;
         S_DATA:  wire_d = shreg_d[0];
         S_PAR:   wire_d = par_d;
         default: wire_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         par_q   <= 1'b0;
         wire_q  <= 1'b1;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         par_q   <= par_d;
         wire_q  <= wire_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: an 8N1 instance checked every cycle against a
// queue-based line model, plus 7E2 / 7O2 instances checked against literal frames.
module tb_uart_tx_fifo;
   localparam int DIV = 4;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic en;
   always #5 clk = ~clk;

   uart_tx_fifo_if #(.DATA_BITS(8)) if0 ();
   uart_tx_fifo_if #(.DATA_BITS(7)) if1 ();
   uart_tx_fifo_if #(.DATA_BITS(7)) if2 ();

   logic       w0, b0, w1, b1, w2, b2;
   logic [2:0] c0, c1, c2;

   uart_tx_fifo #(.DATA_BITS(8), .BAUD(10), .SYS_CLK(40), .PARITY(0), .STOP_BITS(1),
                  .FIFO_DEPTH(DEPTH)) u0 (
      .clk(clk), .rst_n(rst_n), .enable_i(en), .wr_if(if0.slave),
      .tx_wire_o(w0), .busy_o(b0), .fifo_count_o(c0));
   uart_tx_fifo #(.DATA_BITS(7), .BAUD(10), .SYS_CLK(40), .PARITY(2), .STOP_BITS(2),
                  .FIFO_DEPTH(DEPTH)) u1 (
      .clk(clk), .rst_n(rst_n), .enable_i(en), .wr_if(if1.slave),
      .tx_wire_o(w1), .busy_o(b1), .fifo_count_o(c1));
   uart_tx_fifo #(.DATA_BITS(7), .BAUD(10), .SYS_CLK(40), .PARITY(1), .STOP_BITS(2),
                  .FIFO_DEPTH(DEPTH)) u2 (
      .clk(clk), .rst_n(rst_n), .enable_i(en), .wr_if(if2.slave),
      .tx_wire_o(w2), .busy_o(b2), .fifo_count_o(c2));

   int n_vec = 0;
   int n_err = 0;

   // Model: characters waiting, and the per-cycle line levels still to be sent.
   logic [7:0] m_q[$];
   bit         m_sched[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: advance the model at the edge, then compare u0 against it.
   task automatic cycle();
      logic       pushed;
      logic [7:0] pd, ch;
      bit         lv;
      @(posedge clk);
      if (!rst_n) begin
         m_q.delete();
         m_sched.delete();
      end else begin
         pushed = if0.tx_valid && (m_q.size() != DEPTH);
         pd     = if0.tx_data;
         if (m_sched.size() != 0) m_sched.delete(0);
         if (m_sched.size() == 0 && en && m_q.size() != 0) begin
            ch = m_q.pop_front();
            for (int k = 0; k < 10; k++) begin
               lv = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : ch[k-1];
               repeat (DIV) m_sched.push_back(lv);
            end
         end
         if (pushed) m_q.push_back(pd);
      end
      #2;
      chk("line", 32'(w0), 32'((m_sched.size() != 0) ? m_sched[0] : 1'b1));
      chk("busy", 32'(b0), 32'(m_sched.size() != 0));
      chk("count", 32'(c0), 32'(m_q.size()));
      chk("ready", 32'(if0.tx_ready), 32'(m_q.size() != DEPTH));
   endtask

   task automatic push0(input logic [7:0] d);
      if0.tx_data  = d;
      if0.tx_valid = 1'b1;
      cycle();
      if0.tx_valid = 1'b0;
   endtask

   logic [9:0]  e0, g0;
   logic [10:0] e1, e2, g1, g2;
   int          waited;

   initial begin
      rst_n = 1'b1;
      en    = 1'b0;
      if0.tx_valid = 1'b0; if0.tx_data = '0;
      if1.tx_valid = 1'b0; if1.tx_data = '0;
      if2.tx_valid = 1'b0; if2.tx_data = '0;
      #1 rst_n = 1'b0;
      repeat (3) cycle();
      chk("rst_line", 32'(w0), 32'd1);
      chk("rst_busy", 32'(b0), 32'd0);
      chk("rst_count", 32'(c0), 32'd0);
      chk("rst_ready", 32'(if0.tx_ready), 32'd1);
      chk("rst_line1", 32'(w1), 32'd1);
      rst_n = 1'b1;
      en    = 1'b1;
      cycle();

      // 8N1 frame of 0xA5, sampled mid-bit
      e0 = 10'b1101001010;
      push0(8'hA5);
      cycle();
      chk("a5_latency_line", 32'(w0), 32'd0);
      chk("a5_latency_busy", 32'(b0), 32'd1);
      for (int b = 0; b < 10; b++) begin
         repeat ((b == 0) ? 2 : 4) cycle();
         g0[b] = w0;
      end
      for (int b = 0; b < 10; b++) chk($sformatf("a5_bit%0d", b), 32'(g0[b]), 32'(e0[b]));
      cycle();
      chk("a5_busy_last", 32'(b0), 32'd1);
      cycle();
      chk("a5_busy_end", 32'(b0), 32'd0);
      repeat (3) cycle();

      // 7E2 and 7O2 frames of 0x13
      e1 = 11'b11100100110;
      e2 = 11'b11000100110;
      if1.tx_data = 7'h13; if1.tx_valid = 1'b1;
      if2.tx_data = 7'h13; if2.tx_valid = 1'b1;
      cycle();
      if1.tx_valid = 1'b0; if2.tx_valid = 1'b0;
      if1.tx_data = 7'h7F; if2.tx_data = 7'h00;
      cycle();
      chk("p_latency_line", 32'(w1), 32'd0);
      chk("p_latency_busy", 32'(b1), 32'd1);
      for (int b = 0; b < 11; b++) begin
         repeat ((b == 0) ? 2 : 4) cycle();
         g1[b] = w1;
         g2[b] = w2;
      end
      for (int b = 0; b < 11; b++) begin
         chk($sformatf("even_bit%0d", b), 32'(g1[b]), 32'(e1[b]));
         chk($sformatf("odd_bit%0d", b), 32'(g2[b]), 32'(e2[b]));
      end
      cycle();
      chk("p_busy_last", 32'(b1), 32'd1);
      cycle();
      chk("even_busy_end", 32'(b1), 32'd0);
      chk("odd_busy_end", 32'(b2), 32'd0);
      repeat (2) cycle();

      // Fill with enable low, fifth write refused, then drain back-to-back
      en = 1'b0;
      cycle();
      if0.tx_valid = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         if0.tx_data = 8'(i * 8'h11);
         cycle();
      end
      if0.tx_valid = 1'b0;
      chk("full_count", 32'(c0), 32'd4);
      chk("full_ready", 32'(if0.tx_ready), 32'd0);
      en = 1'b1;
      repeat (4 * 10 * DIV + 4) cycle();
      chk("drain_count", 32'(c0), 32'd0);
      chk("drain_busy", 32'(b0), 32'd0);

      // Push on the very edge a frame ends with one entry queued
      push0(8'h61);
      cycle();
      push0(8'h62);
      waited = 0;
      while (m_sched.size() != 1 && waited < 60) begin
         cycle();
         waited++;
      end
      chk("edge_wait_timeout", 32'(waited < 60), 32'd1);
      push0(8'h63);
      chk("pushpop_count", 32'(c0), 32'd1);
      chk("pushpop_start", 32'(w0), 32'd0);
      chk("pushpop_busy", 32'(b0), 32'd1);

      // Enable drops mid-frame with two queued
      push0(8'h64);
      repeat (8) cycle();
      en = 1'b0;
      repeat (50) cycle();
      chk("hold_line", 32'(w0), 32'd1);
      chk("hold_busy", 32'(b0), 32'd0);
      chk("hold_count", 32'(c0), 32'd2);
      en = 1'b1;
      repeat (10) cycle();

      // Asynchronous reset between edges, mid data bit
      chk("pre_rst_busy", 32'(b0), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_line", 32'(w0), 32'd1);
      chk("async_busy", 32'(b0), 32'd0);
      chk("async_count", 32'(c0), 32'd0);
      chk("async_ready", 32'(if0.tx_ready), 32'd1);
      repeat (2) cycle();
      rst_n = 1'b1;
      repeat (60) cycle();
      chk("post_rst_busy", 32'(b0), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an input FIFO, a valid/ready write handshake, and configurable data width, parity and stop bits. It replaces the single-register transmitter in the serial output path. Upstream logic can queue several characters, and the block emits them back-to-back at the configured baud rate. The baud divider is internal, restarts at each frame, and is clocked from the system clock only (no derived clocks).

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5-9.
BAUD, 9600, line rate in bits per second.
SYS_CLK, 12000000, clk frequency in Hz; DIV = SYS_CLK/BAUD (integer division) must be >= 2.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even; 3 is illegal.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
FIFO_DEPTH, 4, FIFO entries; must be a power of 2 and >= 2.

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  when high, permits a new frame to start; an in-flight frame always completes.
tx_data  input  DATA_BITS  character to queue.
tx_valid  input  1  tx_data is valid this cycle.
tx_ready  output  1  FIFO can accept a write (not full).
tx_wire  output  1  serial line; idles high.
busy  output  1  high while a frame is on the line.
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued, unsent characters.

Behaviour:
- Reset (rst_n low, async): tx_wire=1, busy=0, FIFO empty, fifo_count=0, tx_ready=1, state IDLE, baud counter=0, bit index=0. Reset mid-frame aborts the frame immediately; the line returns high and queued data is discarded.
- Write: a write occurs when tx_valid && tx_ready at a posedge. tx_ready = (fifo_count != FIFO_DEPTH), driven combinationally from registered state. If tx_valid is asserted while tx_ready is low, nothing is written. There is no overflow path.
- Pop: in IDLE (or at the end of STOP), if enable=1 and the FIFO is non-empty, the head entry is popped into the shift register at that edge.
- Simultaneous push and pop at one edge: fifo_count is unchanged. A push into an empty FIFO is not poppable until the next edge, so minimum write-to-start-bit latency is 2 cycles.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_wire=1, busy=0. Pop condition met -> START; otherwise stay.
  - START: tx_wire=0 for DIV cycles -> DATA.
  - DATA: LSB first, one bit per DIV cycles. After bit DATA_BITS-1: -> PARITY if PARITY!=0, else -> STOP.
  - PARITY: tx_wire = ^data for even, ~^data for odd (total count of ones including the parity bit is even/odd respectively). Held for DIV cycles -> STOP.
  - STOP: tx_wire=1 for STOP_BITS*DIV cycles. At the end: if pop condition met -> START at the same edge (no idle gap); otherwise -> IDLE.
- busy=1 in every state except IDLE.
- Bit timing: the baud counter counts 0..DIV-1, reloads to 0 on entering START, and advances state/bit on count DIV-1. Every bit lasts exactly DIV clk cycles.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV cycles.
- tx_wire is registered (no glitches). Transmitted data comes only from the shift register, so tx_data changes after a push do not affect queued or in-flight data.
- enable deasserted mid-frame: the current frame completes and no further pop occurs. The FIFO still accepts writes. Re-asserting enable resumes from IDLE on the next edge.
- Counters and pointers wrap modulo FIFO_DEPTH; fifo_count saturates logically at FIFO_DEPTH via tx_ready.

Test Plan:
- Basic 8N1 frame (SYS_CLK=40, BAUD=10, DIV=4): reset, push 0xA5 -> start bit begins 2 cycles after push. Line reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; 40 cycles total; busy high for exactly 40 cycles.
- Parity and 2 stop bits (DATA_BITS=7, PARITY=2, STOP_BITS=2): push 0x13 -> data 1,1,0,0,1,0,0, parity=1, then high for 8 cycles; frame = 11*4 = 44 cycles. Repeat with PARITY=1 -> parity bit=0.
- Back-to-back and full: with enable=0, push 5 values at FIFO_DEPTH=4 -> tx_ready drops after the 4th, the 5th is not written, fifo_count=4. Raise enable -> 4 frames with no idle cycles between the last stop bit and the next start bit, sent in push order.
- Simultaneous push/pop: push on the exact edge a frame ends with fifo_count=1 -> fifo_count stays 1; next frame starts that edge.
- enable drop mid-frame: deassert enable during DATA with 2 queued -> the current frame finishes, tx_wire stays 1, fifo_count=2 until enable returns.
- Async reset mid-frame: assert rst_n=0 during a data bit between clock edges -> tx_wire=1 and busy=0 without waiting for a clock edge; fifo_count=0. After release, no residual frame is sent.
